hw2_pipe_bist_driver: RTL and testbench

//  Self-checking stimulus/response engine for the two-stage C*(A+/-B) datapath (plain and clock-gated).

---
 rtl/hw2_pipe_bist_driver.sv | 118 +++++++++++
 tb/tb_hw2_pipe_bist_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hw2_pipe_bist_driver.sv
// hw2_pipe_bist_driver: LFSR-driven self-check of the two-stage C*(A+/-B) pipe.
// Optional result MISR on signature_o when BIST_SIGNATURE_EN is defined.
module hw2_pipe_bist_driver #(
    parameter int          N_VECTORS = 200,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] SEED      = 32'h1D872B41
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start_i,
    output logic [7:0]  a_o,
    output logic [7:0]  b_o,
    output logic [7:0]  c_o,
    output logic        s_o,
    input  logic [15:0] result_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_count_o,
    output logic [15:0] first_fail_o,
    output logic [15:0] signature_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0] LAST_VEC  = 16'(N_VECTORS - 1);
    localparam logic [2:0]  DRAIN_LEN = 3'(LATENCY);
    state_t              r_state, w_next;
    logic [31:0]         r_lfsr;
    logic [15:0]         r_vec, r_cmp, r_err, r_ff;
    logic [2:0]          r_drain;
    logic [15:0]         r_exp [LATENCY];
    logic [LATENCY-1:0]  r_vld;
    logic                w_start, w_run, w_cmp, w_mis;
    logic [15:0]         w_a, w_b, w_c, w_exp;
    assign w_start = (r_state == IDLE || r_state == DONE) && start_i;
    assign w_run   = r_state == RUN;
    assign w_cmp   = (w_run || r_state == DRAIN) && r_vld[LATENCY-1];
    assign w_mis   = w_cmp && (result_i != r_exp[LATENCY-1]);
    assign w_a     = {8'h00, r_lfsr[7:0]};
    assign w_b     = {8'h00, r_lfsr[15:8]};
    assign w_c     = {8'h00, r_lfsr[23:16]};
    assign w_exp   = r_lfsr[24] ? w_c * (w_a + w_b) : w_c * (w_a - w_b);
    assign a_o          = w_run ? r_lfsr[7:0] : 8'h00;
    assign b_o          = w_run ? r_lfsr[15:8] : 8'h00;
    assign c_o          = w_run ? r_lfsr[23:16] : 8'h00;
    assign s_o          = w_run & r_lfsr[24];
    assign busy_o       = w_run || r_state == DRAIN;
    assign done_o       = r_state == DONE;
    assign pass_o       = done_o && r_err == 16'h0000;
    assign err_count_o  = r_err;
    assign first_fail_o = r_ff;
    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = RUN;
        else if (w_run && r_vec == LAST_VEC)
            w_next = DRAIN;
        else if (r_state == DRAIN && r_drain == DRAIN_LEN)
            w_next = DONE;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_lfsr  <= SEED_EFF;
            r_vec   <= '0;
            r_cmp   <= '0;
            r_err   <= '0;
            r_ff    <= 16'hFFFF;
            r_drain <= '0;
            r_vld   <= '0;
        end else begin
            r_state <= w_next;
            r_drain <= (r_state == DRAIN) ? r_drain + 3'd1 : 3'd0;
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_exp[i] <= r_exp[i-1];
                r_vld[i] <= r_vld[i-1];
            end
            r_exp[0] <= w_exp;
            r_vld[0] <= w_run;
            if (w_start) begin
                r_lfsr <= SEED_EFF;
                r_vec  <= '0;
                r_cmp  <= '0;
                r_err  <= '0;
                r_ff   <= 16'hFFFF;
                r_vld  <= '0;
            end else begin
                if (w_run) begin
                    r_lfsr <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
                    r_vec  <= r_vec + 16'd1;
                end
                // results exit in issue order, so the compare count is the vector index
                if (w_cmp) begin
                    r_cmp <= r_cmp + 16'd1;
                    if (w_mis) begin
                        r_err <= (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
                        if (r_err == 16'h0000)
                            r_ff <= r_cmp;
                    end
                end
            end
        end
    end
`ifdef BIST_SIGNATURE_EN
    logic [15:0] r_sig;
    always_ff @(posedge CLK) begin
        if (RESET)
            r_sig <= '0;
        else if (w_start)
            r_sig <= 16'hFFFF;
        else if (w_cmp)
            r_sig <= {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ result_i;
    end
    assign signature_o = r_sig;
`else
    assign signature_o = 16'h0000;
`endif
endmodule

// File: tb/tb_hw2_pipe_bist_driver.sv
// tb_hw2_pipe_bist_driver: ideal/faulty pipe models around the BIST driver, checked against an LFSR/arithmetic reference.
module tb_hw2_pipe_bist_driver;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  a_o, b_o, c_o;
    logic        s_o;
    logic [15:0] result_i;
    logic        busy_o, done_o, pass_o;
    logic [15:0] err_count_o, first_fail_o, signature_o;
    logic        start5 = 1'b0;
    logic [7:0]  a5, b5, c5;
    logic        s5;
    logic [15:0] res5;
    logic        busy5, done5, pass5;
    logic [15:0] err5, ff5, sig5;
    int n_chk = 0;
    int n_fail = 0;
    always #5 CLK = ~CLK;
    hw2_pipe_bist_driver u_dut (
        .CLK(CLK), .RESET(RESET), .start_i(start_i),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .s_o(s_o), .result_i(result_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .err_count_o(err_count_o), .first_fail_o(first_fail_o), .signature_o(signature_o)
    );
    hw2_pipe_bist_driver #(.N_VECTORS(1), .LATENCY(2), .SEED(32'h00020503)) u_one (
        .CLK(CLK), .RESET(RESET), .start_i(start5),
        .a_o(a5), .b_o(b5), .c_o(c5), .s_o(s5), .result_i(res5),
        .busy_o(busy5), .done_o(done5), .pass_o(pass5),
        .err_count_o(err5), .first_fail_o(ff5), .signature_o(sig5)
    );
    function automatic logic [15:0] f_expect(int a, int b, int c, int s);
        int r;
        r = (s != 0) ? c * (a + b) : c * (a - b);
        return r[15:0];
    endfunction
    function automatic logic [15:0] f_misr(logic [15:0] s, logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction
    // Two-register pipe models; the main one can inject faults by vector index
    logic        stuck = 1'b0;
    int          fa = -1;
    int          fb = -1;
    logic        flip5 = 1'b0;
    int          drv_cnt = 0;
    logic [15:0] p_v [2];
    int          p_i [2];
    logic [15:0] q5 [2];
    always @(posedge CLK) begin
        drv_cnt <= busy_o ? drv_cnt + 1 : 0;
        p_v[0]  <= f_expect(int'(a_o), int'(b_o), int'(c_o), int'(s_o));
        p_i[0]  <= drv_cnt;
        p_v[1]  <= p_v[0];
        p_i[1]  <= p_i[0];
        q5[0]   <= f_expect(int'(a5), int'(b5), int'(c5), int'(s5));
        q5[1]   <= q5[0];
    end
    assign result_i = stuck ? 16'h0000 : p_v[1] ^ {15'b0, (p_i[1] == fa || p_i[1] == fb)};
    assign res5 = q5[1] ^ {15'b0, flip5};
    logic [7:0]  ma [200];
    logic [7:0]  mb [200];
    logic [7:0]  mc [200];
    logic        ms [200];
    logic [15:0] me [200];
    typedef struct {
        bit stuck;
        int fa;
        int fb;
        int hold;
        int exp_err;
        int exp_ff;
        bit exp_pass;
    } vec_t;
    vec_t tbl [7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic do_run(input int hold, output int cyc);
        @(negedge CLK);
        start_i = 1'b1;
        @(posedge CLK);
        #1;
        cyc = 0;
        if (hold <= 0) start_i = 1'b0;
        while (!done_o && cyc < 1000) begin
            if (cyc < 200)
                chk("ops", {a_o, b_o, c_o, 7'b0, s_o}, {ma[cyc], mb[cyc], mc[cyc], 7'b0, ms[cyc]});
            if (cyc == 200) begin
                chk("ops_drain", {a_o, b_o, c_o, 7'b0, s_o}, 32'h0);
                chk("busy_drain", 32'(busy_o), 32'h1);
            end
            @(posedge CLK);
            #1;
            cyc++;
            if (cyc >= hold) start_i = 1'b0;
        end
        start_i = 1'b0;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] l;
        int cyc, nz, nz_first;
        l = 32'h1D872B41;
        nz = 0;
        nz_first = 16'hFFFF;
        for (int k = 0; k < 200; k++) begin
            ma[k] = l[7:0];
            mb[k] = l[15:8];
            mc[k] = l[23:16];
            ms[k] = l[24];
            me[k] = f_expect(int'(l[7:0]), int'(l[15:8]), int'(l[23:16]), int'(l[24]));
            if (me[k] != 16'h0) begin
                if (nz == 0) nz_first = k;
                nz++;
            end
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        tbl[0] = '{1'b0, -1, -1, 0, 0, 16'hFFFF, 1'b1};
        tbl[1] = '{1'b0, 5, -1, 0, 1, 5, 1'b0};
        tbl[2] = '{1'b0, 0, 199, 0, 2, 0, 1'b0};
        tbl[3] = '{1'b1, -1, -1, 0, nz, nz_first, nz == 0};
        tbl[4] = '{1'b0, -1, -1, 150, 0, 16'hFFFF, 1'b1};
        for (int i = 5; i < 7; i++) begin
            tbl[i].stuck = 1'b0;
            tbl[i].fa = int'($urandom_range(0, 199));
            tbl[i].fb = int'($urandom_range(0, 199));
            tbl[i].hold = 0;
            tbl[i].exp_err = (tbl[i].fa == tbl[i].fb) ? 1 : 2;
            tbl[i].exp_ff = (tbl[i].fa < tbl[i].fb) ? tbl[i].fa : tbl[i].fb;
            tbl[i].exp_pass = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_pass", 32'(pass_o), 0);
        chk("rst_err", 32'(err_count_o), 0);
        chk("rst_ff", 32'(first_fail_o), 32'hFFFF);
        chk("rst_ops", {a_o, b_o, c_o, 7'b0, s_o}, 0);
        chk("rst_sig", 32'(signature_o), 0);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 7; i++) begin
            logic [15:0] sg;
            stuck = tbl[i].stuck;
            fa = tbl[i].fa;
            fb = tbl[i].fb;
            do_run(tbl[i].hold, cyc);
            chk("done_time", 32'(cyc), 203);
            chk("err", 32'(err_count_o), 32'(tbl[i].exp_err));
            chk("first_fail", 32'(first_fail_o), 32'(tbl[i].exp_ff));
            chk("pass", 32'(pass_o), 32'(tbl[i].exp_pass));
            sg = 16'hFFFF;
            for (int k = 0; k < 200; k++)
                sg = f_misr(sg, tbl[i].stuck ? 16'h0 : me[k] ^ {15'b0, (k == tbl[i].fa || k == tbl[i].fb)});
`ifdef BIST_SIGNATURE_EN
            chk("signature", 32'(signature_o), 32'(sg));
`else
            chk("signature_off", 32'(signature_o), 32'({16'h0, sg} & 32'h0));
`endif
            repeat (3) @(posedge CLK);
            #1;
            chk("done_hold", 32'(done_o), 1);
            chk("err_hold", 32'(err_count_o), 32'(tbl[i].exp_err));
        end
        // Reset in the middle of a run that already has an error recorded
        stuck = 1'b0;
        fa = 5;
        fb = -1;
        @(negedge CLK);
        start_i = 1'b1;
        @(posedge CLK);
        #1;
        start_i = 1'b0;
        repeat (50) @(posedge CLK);
        #1;
        chk("mid_busy", 32'(busy_o), 1);
        chk("mid_err", 32'(err_count_o), 1);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_ops", {a_o, b_o, c_o, 7'b0, s_o}, 0);
        chk("abort_err", 32'(err_count_o), 0);
        chk("abort_ff", 32'(first_fail_o), 32'hFFFF);
        @(negedge CLK);
        RESET = 1'b0;
        fa = -1;
        do_run(0, cyc);
        chk("replay_time", 32'(cyc), 203);
        chk("replay_err", 32'(err_count_o), 0);
        chk("replay_pass", 32'(pass_o), 1);
        // Single-vector instance: seed forces a=3, b=5, c=2, s=0
        for (int r = 0; r < 2; r++) begin
            logic [15:0] sg;
            flip5 = (r == 1);
            @(negedge CLK);
            start5 = 1'b1;
            @(posedge CLK);
            #1;
            start5 = 1'b0;
            chk("one_ops", {a5, b5, c5, 7'b0, s5}, {8'd3, 8'd5, 8'd2, 8'd0});
            chk("one_expect", 32'(f_expect(int'(a5), int'(b5), int'(c5), int'(s5))), 32'hFFFC);
            cyc = 0;
            while (!done5 && cyc < 100) begin
                @(posedge CLK);
                #1;
                cyc++;
            end
            chk("one_done_time", 32'(cyc), 4);
            chk("one_err", 32'(err5), 32'(r));
            chk("one_ff", 32'(ff5), (r == 1) ? 32'h0 : 32'hFFFF);
            chk("one_pass", 32'(pass5), 32'(r == 0));
            sg = f_misr(16'hFFFF, 16'hFFFC ^ {15'b0, flip5});
`ifdef BIST_SIGNATURE_EN
            chk("one_sig", 32'(sig5), 32'(sg));
`else
            chk("one_sig_off", 32'(sig5), 32'({16'h0, sg} & 32'h0));
`endif
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
